// File: rtl/reg_bank_3r1w_if.sv
// Register-bank access bus for reg_bank_3r1w.
// Groups the write enable, the three addresses, the write data and the three
// read results. The master drives addresses/data; the slave (the register
// bank) returns the combinational read data.
//   sinal    : write enable, active-high
//   entrada1 : read address, port 1
//   entrada2 : read address, port 2
//   entrada3 : write address, also read address for port 3
//   dado     : write data
//   saida1-3 : contents of the addressed registers
interface reg_bank_3r1w_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              sinal;
  logic [ADDR_W-1:0] entrada1;
  logic [ADDR_W-1:0] entrada2;
  logic [ADDR_W-1:0] entrada3;
  logic [DATA_W-1:0] dado;
  logic [DATA_W-1:0] saida1;
  logic [DATA_W-1:0] saida2;
  logic [DATA_W-1:0] saida3;

  modport master (
    output sinal, entrada1, entrada2, entrada3, dado,
    input  saida1, saida2, saida3
  );

  modport slave (
    input  sinal, entrada1, entrada2, entrada3, dado,
    output saida1, saida2, saida3
  );
endinterface

// File: rtl/reg_bank_3r1w.sv
// 16 x 16-bit general-purpose register file: two read ports plus one
// combined write/read port (write address also selects read port 3).
// Reads are combinational; the write and the reset are synchronous.
// R0 is an ordinary register (no hardwired zero).
//
// Ports:
//   CLOCK_50 : clock, all state updates on the rising edge
//   RESET    : synchronous, active-high; clears all registers, beats a write
//   bus      : reg_bank_3r1w_if.slave (sinal, entrada1-3, dado, saida1-3)
//
// Optional feature macro: REG_BANK_WRITE_BYPASS_EN
//   Defined   : a pending write (sinal=1, RESET=0) is forwarded to saida1/2
//               when their address matches entrada3, and to saida3.
//   Undefined : reads always return stored contents.
module reg_bank_3r1w #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic            CLOCK_50,
  input logic            RESET,
  reg_bank_3r1w_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];

  // Next state: reset wins over a simultaneous write.
  always_comb begin
    regs_d = regs_q;
    if (RESET) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_d[i] = '0;
      end
    end else if (bus.sinal) begin
      regs_d[bus.entrada3] = bus.dado;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    regs_q <= regs_d;
  end

`ifdef REG_BANK_WRITE_BYPASS_EN
  // Forward the value being committed so decode needs no bubble.
  logic fwd_en;
  assign fwd_en = bus.sinal && !RESET;

  always_comb begin
    bus.saida1 = (fwd_en && (bus.entrada1 == bus.entrada3)) ? bus.dado
                                                            : regs_q[bus.entrada1];
    bus.saida2 = (fwd_en && (bus.entrada2 == bus.entrada3)) ? bus.dado
                                                            : regs_q[bus.entrada2];
    bus.saida3 = fwd_en ? bus.dado : regs_q[bus.entrada3];
  end
`else
  always_comb begin
    bus.saida1 = regs_q[bus.entrada1];
    bus.saida2 = regs_q[bus.entrada2];
    bus.saida3 = regs_q[bus.entrada3];
  end
`endif

endmodule

// File: tb/tb_reg_bank_3r1w.sv
// Scoreboard bench for reg_bank_3r1w: stimulus pushes expected read values
// into a queue and raises a sample event; a monitor pops and compares.
module tb_reg_bank_3r1w;

  logic clk;
  logic rst;

  reg_bank_3r1w_if #(.DATA_W(16), .ADDR_W(4)) bus_if ();

  reg_bank_3r1w #(
    .DATA_W(16),
    .ADDR_W(4)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] e3;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   fails  = 0;

  // Monitor: compare the three read ports against the oldest expectation.
  always @(sample_ev) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_empty: sample with no expectation queued");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (bus_if.saida1 !== e.e1) begin
        fails++;
        $display("FAIL %s saida1: got %h expected %h", e.name, bus_if.saida1, e.e1);
      end
      checks++;
      if (bus_if.saida2 !== e.e2) begin
        fails++;
        $display("FAIL %s saida2: got %h expected %h", e.name, bus_if.saida2, e.e2);
      end
      checks++;
      if (bus_if.saida3 !== e.e3) begin
        fails++;
        $display("FAIL %s saida3: got %h expected %h", e.name, bus_if.saida3, e.e3);
      end
    end
  end

  // Set read addresses, then queue the expected values and request a sample.
  task automatic check(input string name, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] a3, input logic [15:0] e1, input logic [15:0] e2,
                       input logic [15:0] e3);
    exp_t e;
    bus_if.entrada1 = a1;
    bus_if.entrada2 = a2;
    bus_if.entrada3 = a3;
    #1;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    e.e3   = e3;
    exp_q.push_back(e);
    ->sample_ev;
    #1;
  endtask

  task automatic write(input logic en, input logic [3:0] addr, input logic [15:0] data);
    bus_if.sinal    = en;
    bus_if.entrada3 = addr;
    bus_if.dado     = data;
    @(posedge clk);
    #1;
    bus_if.sinal = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pre1, pre3;

    rst             = 1'b1;
    bus_if.sinal    = 1'b0;
    bus_if.entrada1 = '0;
    bus_if.entrada2 = '0;
    bus_if.entrada3 = '0;
    bus_if.dado     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_init", 4'd0, 4'd15, 4'd7, 16'h0000, 16'h0000, 16'h0000);

    // 1: random writes, then a single reset edge clears everything.
    for (int i = 0; i < 8; i++) begin
      write(1'b1, 4'($urandom_range(0, 15)), 16'($urandom) | 16'h0001);
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      check("reset_sweep", 4'(i), 4'(15 - i), 4'(i), 16'h0000, 16'h0000, 16'h0000);
    end

    // 2: basic write then read.
    write(1'b1, 4'd5, 16'h1234);
    check("write_read", 4'd5, 4'd0, 4'd5, 16'h1234, 16'h0000, 16'h1234);

    // 3: write-enable gating, then full sweep through both read ports.
    write(1'b0, 4'd7, 16'hBEEF);
    check("we_gating", 4'd7, 4'd5, 4'd7, 16'h0000, 16'h1234, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      write(1'b1, 4'(i), 16'hA000 + 16'(i));
    end
    for (int i = 0; i < 16; i++) begin
      check("sweep", 4'(i), 4'(15 - i), 4'(i), 16'hA000 + 16'(i),
            16'hA000 + 16'(15 - i), 16'hA000 + 16'(i));
    end
    check("same_addr_all_ports", 4'd12, 4'd12, 4'd12, 16'hA00C, 16'hA00C, 16'hA00C);

    // 4: reset beats a simultaneous write.
    rst             = 1'b1;
    bus_if.sinal    = 1'b1;
    bus_if.entrada3 = 4'd3;
    bus_if.dado     = 16'hFFFF;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus_if.sinal = 1'b0;
    @(negedge clk);
    check("reset_priority", 4'd3, 4'd4, 4'd3, 16'h0000, 16'h0000, 16'h0000);

    // 5: same-cycle read of the register being written.
    write(1'b1, 4'd2, 16'h0011);
`ifdef REG_BANK_WRITE_BYPASS_EN
    pre1 = 16'h0022;
    pre3 = 16'h0022;
`else
    pre1 = 16'h0011;
    pre3 = 16'h0011;
`endif
    @(negedge clk);
    bus_if.sinal = 1'b1;
    bus_if.dado  = 16'h0022;
    check("hazard_pre", 4'd2, 4'd0, 4'd2, pre1, 16'h0000, pre3);
    @(posedge clk);
    #1;
    bus_if.sinal = 1'b0;
    @(negedge clk);
    check("hazard_post", 4'd2, 4'd0, 4'd2, 16'h0022, 16'h0000, 16'h0022);

    // 6: back-to-back writes to one register; neighbours untouched.
    bus_if.sinal    = 1'b1;
    bus_if.entrada3 = 4'd9;
    bus_if.dado     = 16'h0001;
    @(posedge clk);
    #1;
    bus_if.dado = 16'h0002;
    @(posedge clk);
    #1;
    bus_if.sinal = 1'b0;
    @(negedge clk);
    check("b2b_r9", 4'd9, 4'd8, 4'd10, 16'h0002, 16'h0000, 16'h0000);

    // Idempotent rewrite of the same value.
    write(1'b1, 4'd9, 16'h0002);
    check("idempotent", 4'd9, 4'd2, 4'd9, 16'h0002, 16'h0022, 16'h0002);

    #5;
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
